// File: rtl/clk_phase_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clk_phase_chk : quadrature clock checker (rotation, dwell, lock, errors) |
// | Optional macro CLK_PHASE_CHK_REV_EN enables reverse-rotation tracking.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module clk_phase_chk #(
    parameter int QUARTER  = 1,
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8,
    parameter int DW_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_0,
    input  logic             clk_90,
    input  logic             clk_180,
    input  logic             clk_270,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             phase_err,
    output logic [ERR_W-1:0] err_count,
    output logic             dir
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [DW_W-1:0] c_QTR  = DW_W'(QUARTER);
    localparam logic [DW_W-1:0] c_QTR1 = DW_W'(QUARTER + 1);
    localparam logic [GW-1:0]   c_LOCK = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      s_q;
    logic [1:0]      cur_q;
    logic [DW_W-1:0] dwell_q;
    logic [GW-1:0]   good_q;
    logic            first_q;

    logic            w_legal;
    logic [1:0]      w_quad;
    logic [1:0]      w_step;
    logic            w_change;
    logic            w_dir_ok;
    logic            w_short;
    logic            w_stall;
    logic            w_viol;
    logic [GW-1:0]   good_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= 4'b0000;
        end else begin
            s_q <= {clk_0, clk_90, clk_180, clk_270};
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_quad  = 2'd0;
        case (s_q)
            4'b1001: w_quad = 2'd0;
            4'b1100: w_quad = 2'd1;
            4'b0110: w_quad = 2'd2;
            4'b0011: w_quad = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_step   = w_quad - cur_q;
    assign w_change = (w_step != 2'd0);

`ifdef CLK_PHASE_CHK_REV_EN
    logic dir_q;
    // The first step out of a fresh acquisition chooses the rotation sense.
    assign w_dir_ok = first_q ? (w_step == 2'd1 || w_step == 2'd3)
                              : (w_step == (dir_q ? 2'd3 : 2'd1));
    assign dir      = dir_q;
`else
    assign w_dir_ok = (w_step == 2'd1);
    assign dir      = 1'b0;
`endif

    // The first quadrant may be partial, so only its overstay is checked.
    assign w_short = w_change && !first_q && (dwell_q < c_QTR);
    assign w_stall = !w_change && (dwell_q >= c_QTR);
    assign w_viol  = !w_legal || w_stall || w_short || (w_change && !w_dir_ok);
    assign good_d  = good_q + GW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEARCH;
            cur_q     <= 2'd0;
            dwell_q   <= '0;
            good_q    <= '0;
            first_q   <= 1'b0;
            phase     <= 2'd0;
            locked    <= 1'b0;
            phase_err <= 1'b0;
            err_count <= '0;
`ifdef CLK_PHASE_CHK_REV_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            phase_err <= 1'b0;
            if (w_legal) begin
                phase <= w_quad;
            end
            case (state_q)
                SEARCH: begin
                    if (w_legal) begin
                        cur_q   <= w_quad;
                        dwell_q <= DW_W'(1);
                        good_q  <= '0;
                        first_q <= 1'b1;
                        state_q <= ACQUIRE;
                    end
                end
                default: begin
                    if (w_viol) begin
                        phase_err <= 1'b1;
                        locked    <= 1'b0;
                        good_q    <= '0;
                        state_q   <= SEARCH;
`ifdef CLK_PHASE_CHK_REV_EN
                        dir_q     <= 1'b0;
`endif
                        if (state_q == LOCKED && !(&err_count)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                    end else if (w_change) begin
                        cur_q   <= w_quad;
                        dwell_q <= DW_W'(1);
                        first_q <= 1'b0;
`ifdef CLK_PHASE_CHK_REV_EN
                        if (first_q) begin
                            dir_q <= (w_step == 2'd3);
                        end
`endif
                        if (state_q == ACQUIRE) begin
                            good_q <= good_d;
                            if (good_d == c_LOCK) begin
                                state_q <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end
                    end else if (dwell_q != c_QTR1) begin
                        dwell_q <= dwell_q + DW_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
